dtw_traceback: RTL and testbench

Downstream consumer of the DTW processing-element array. Captures the 2-bit back-pointer (path code) produced by each PE for every cell (i,j) of the cost matrix. Once the matrix is complete, walks the back-pointers from (N-1,M-1) to (0,0). Streams the warping path out one cell per handshake, then reports the final accumulated distance, the path length and an error flag.

---
 rtl/dtw_traceback.sv | 112 +++++++++++
 tb/tb_dtw_traceback.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dtw_traceback.sv
// dtw_traceback: capture DTW back-pointers, then stream the warping path and report distance, length and error
module dtw_traceback #(
  parameter int N = 32,
  parameter int M = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_i,
  input  logic [4:0]  wr_j,
  input  logic [1:0]  wr_path,
  input  logic        mat_done,
  input  logic [15:0] d_final,
  output logic        busy,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [4:0]  o_i,
  output logic [4:0]  o_j,
  output logic        o_last,
  output logic        res_valid,
  input  logic        res_ack,
  output logic [15:0] res_dist,
  output logic [5:0]  res_len,
  output logic        res_err
);
  localparam int IW = $clog2(N);
  localparam int JW = $clog2(M);
  localparam logic [4:0] IMAX = 5'(N - 1);
  localparam logic [4:0] JMAX = 5'(M - 1);
  localparam logic [5:0] NL = 6'(N);
  localparam logic [5:0] ML = 6'(M);
  typedef enum logic [1:0] {IDLE, TRACE, DONE} state_t;
  state_t state;
  logic [1:0] mem [N][M];
  logic wr_oor, wr_in, interior, step_err, di, dj, n_last;
  logic [1:0] code, n_code, s_code;
  logic [4:0] ni, nj;
  always_comb begin
    wr_in = ({1'b0, wr_i} < NL) && ({1'b0, wr_j} < ML);
    s_code = (wr_en && wr_i == IMAX && wr_j == JMAX) ? wr_path : mem[IMAX[IW-1:0]][JMAX[JW-1:0]];
    code = mem[o_i[IW-1:0]][o_j[JW-1:0]];
    interior = |o_i && |o_j;
    step_err = interior && code == 2'b00;
    di = interior ? code[1] : (o_j == 5'd0 && |o_i);
    dj = interior ? code[0] : (o_i == 5'd0 && |o_j);
    ni = o_i - {4'b0, di};
    nj = o_j - {4'b0, dj};
    n_code = mem[ni[IW-1:0]][nj[JW-1:0]];
    n_last = (ni == 5'd0 && nj == 5'd0) || (|ni && |nj && n_code == 2'b00);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      o_valid <= 1'b0;
      o_i <= 5'd0;
      o_j <= 5'd0;
      o_last <= 1'b0;
      res_valid <= 1'b0;
      res_dist <= 16'd0;
      res_len <= 6'd0;
      res_err <= 1'b0;
      wr_oor <= 1'b0;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < M; b++)
          mem[a][b] <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en && wr_in) mem[wr_i[IW-1:0]][wr_j[JW-1:0]] <= wr_path;
          if (wr_en && !wr_in) wr_oor <= 1'b1;
          if (mat_done) begin
            state <= TRACE;
            busy <= 1'b1;
            o_valid <= 1'b1;
            o_i <= IMAX;
            o_j <= JMAX;
            o_last <= s_code == 2'b00;
            res_dist <= d_final;
            res_len <= 6'd0;
            res_err <= wr_oor | (wr_en && !wr_in);
            wr_oor <= 1'b0;
          end
        end
        TRACE: begin
          if (o_ready) begin
            res_len <= res_len + 6'd1;
            if (o_last) begin
              state <= DONE;
              o_valid <= 1'b0;
              o_last <= 1'b0;
              res_valid <= 1'b1;
              res_err <= res_err | step_err;
            end else begin
              o_i <= ni;
              o_j <= nj;
              o_last <= n_last;
            end
          end
        end
        DONE: begin
          if (res_ack) begin
            state <= IDLE;
            res_valid <= 1'b0;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtw_traceback.sv
// tb_dtw_traceback: directed scoreboard bench for dtw_traceback at N=4, M=6
module tb_dtw_traceback;
  localparam int N = 4;
  localparam int M = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [4:0] wr_i = '0;
  logic [4:0] wr_j = '0;
  logic [1:0] wr_path = '0;
  logic mat_done = 1'b0;
  logic [15:0] d_final = '0;
  logic busy, o_valid, o_last, res_valid, res_err;
  logic o_ready = 1'b0;
  logic res_ack = 1'b0;
  logic [4:0] o_i, o_j;
  logic [15:0] res_dist;
  logic [5:0] res_len;
  typedef struct packed {logic [4:0] i; logic [4:0] j; logic last;} step_t;
  step_t q[$];
  logic [1:0] mm [N][M];
  int vectors = 0;
  int miss = 0;
  always #5 clk = ~clk;
  dtw_traceback #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_path(wr_path),
    .mat_done(mat_done), .d_final(d_final), .busy(busy), .o_valid(o_valid), .o_ready(o_ready),
    .o_i(o_i), .o_j(o_j), .o_last(o_last), .res_valid(res_valid), .res_ack(res_ack),
    .res_dist(res_dist), .res_len(res_len), .res_err(res_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_i", o_i, 0);
    chk("rst_o_j", o_j, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_dist", res_dist, 0);
    chk("rst_res_len", res_len, 0);
    chk("rst_res_err", res_err, 0);
  endtask
  task automatic clr();
    for (int a = 0; a < N; a++)
      for (int b = 0; b < M; b++)
        mm[a][b] = 2'b00;
  endtask
  task automatic wr(input int i, input int j, input logic [1:0] p);
    wr_en = 1'b1;
    wr_i = 5'(i);
    wr_j = 5'(j);
    wr_path = p;
    if (i < N && j < M) mm[i][j] = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic fill(input logic [1:0] p);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        wr(i, j, p);
  endtask
  task automatic model();
    int i = N - 1;
    int j = M - 1;
    logic [1:0] c;
    logic last;
    q.delete();
    for (int k = 0; k < N + M; k++) begin
      c = mm[i][j];
      last = (i == 0 && j == 0) || (i > 0 && j > 0 && c == 2'b00);
      q.push_back({5'(i), 5'(j), last});
      if (last) break;
      if (i == 0) j--;
      else if (j == 0) i--;
      else begin
        if (c[1]) i--;
        if (c[0]) j--;
      end
    end
  endtask
  task automatic trace(input logic [15:0] d, input int mode, input int exp_len, input logic exp_err,
                       input logic inject, input logic sw, input int si, input int sj, input logic [1:0] sp);
    int cyc = 0;
    logic acc;
    if (sw) begin
      wr_en = 1'b1;
      wr_i = 5'(si);
      wr_j = 5'(sj);
      wr_path = sp;
      mm[si][sj] = sp;
    end
    model();
    mat_done = 1'b1;
    d_final = d;
    o_ready = 1'b0;
    @(negedge clk);
    mat_done = 1'b0;
    wr_en = 1'b0;
    chk("start_busy", busy, 1);
    while (q.size() > 0 && cyc < 300) begin
      o_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (inject && cyc == 1) begin
        wr_en = 1'b1;
        wr_i = 5'd3;
        wr_j = 5'd5;
        wr_path = 2'b01;
        mat_done = 1'b1;
      end
      chk("step_valid", o_valid, 1);
      if (!o_valid) break;
      chk("step", {o_i, o_j, o_last}, q[0]);
      acc = o_ready;
      @(negedge clk);
      wr_en = 1'b0;
      mat_done = 1'b0;
      if (acc) void'(q.pop_front());
      cyc++;
    end
    o_ready = 1'b0;
    chk("steps_drained", q.size(), 0);
    if (mode == 0) chk("step_cycles", cyc, exp_len);
    chk("res_valid", res_valid, 1);
    chk("done_o_valid", o_valid, 0);
    chk("done_busy", busy, 1);
    chk("res_dist", res_dist, d);
    chk("res_len", res_len, exp_len);
    chk("res_err", res_err, exp_err);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk("ack_res_valid", res_valid, 0);
    chk("ack_busy", busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    clr();
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    fill(2'b11);
    trace(16'h0123, 0, 6, 0, 0, 0, 0, 0, 2'b00);
    wr(3, 5, 2'b01);
    wr(3, 4, 2'b01);
    wr(3, 3, 2'b10);
    trace(16'h0456, 0, 7, 0, 0, 0, 0, 0, 2'b00);
    trace(16'h0789, 1, 7, 0, 0, 0, 0, 0, 2'b00);
    fill(2'b11);
    trace(16'h1111, 0, 6, 0, 1, 0, 0, 0, 2'b00);
    trace(16'h2222, 0, 6, 0, 0, 0, 0, 0, 2'b00);
    wr(N, 0, 2'b11);
    trace(16'h3333, 0, 6, 1, 0, 0, 0, 0, 2'b00);
    trace(16'h4444, 0, 6, 0, 0, 0, 0, 0, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        if (!(i == 2 && j == 2)) wr(i, j, 2'b11);
    wr(3, 5, 2'b01);
    wr(3, 4, 2'b01);
    trace(16'h5555, 0, 4, 1, 0, 0, 0, 0, 2'b00);
    fill(2'b11);
    mat_done = 1'b1;
    d_final = 16'h9999;
    @(negedge clk);
    mat_done = 1'b0;
    o_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    o_ready = 1'b0;
    clr();
    trace(16'h6666, 0, 1, 1, 0, 0, 0, 0, 2'b00);
    trace(16'h7777, 0, 2, 1, 0, 1, 3, 5, 2'b10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
